// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, presents one registered
// instruction per cycle to the controller and applies stall, flush and PC redirects.
module fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] NOP      = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  pccontrol,
  input  logic        flush,
  input  logic [7:0]  target,
  input  logic        stall,
  input  logic [7:0]  imem_rdata,
  input  logic        imem_ready,
  output logic [7:0]  imem_addr,
  output logic [7:0]  instr,
  output logic [7:0]  prevInstr,
  output logic        instr_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic {StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  instr_q, instr_d;
  logic [7:0]  prev_q, prev_d;
  logic        valid_q, valid_d;
  logic [15:0] count_q, count_d;

  logic [2:0]  eff_cmd;
  logic        cmd_rel, cmd_abs, cmd_halt;

  // A bubble in instr carries no command; unknown encodings fall back to sequential.
  assign eff_cmd  = valid_q ? pccontrol : 3'b000;
  assign cmd_rel  = (eff_cmd == 3'b001);
  assign cmd_abs  = (eff_cmd == 3'b010);
  assign cmd_halt = (eff_cmd == 3'b100);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    prev_d  = prev_q;
    valid_d = valid_q;
    count_d = count_q;
    unique case (state_q)
      StRun: begin
        if (!stall) begin
          if (cmd_halt) begin
            state_d = StHalt;
            instr_d = NOP;
            valid_d = 1'b0;
          end else begin
            // Redirects win over imem_ready so a taken branch is never dropped.
            // An 8-bit add is the same as adding the sign-extended offset modulo 256.
            if (cmd_rel) begin
              pc_d = pc_q + target;
            end else if (cmd_abs) begin
              pc_d = target;
            end else if (flush || imem_ready) begin
              pc_d = pc_q + 8'd1;
            end

            if (flush || !imem_ready) begin
              instr_d = NOP;
              valid_d = 1'b0;
            end else begin
              instr_d = imem_rdata;
              valid_d = 1'b1;
              count_d = count_q + 16'd1;
              if (valid_q) begin
                prev_d = instr_q;
              end
            end
          end
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      prev_q  <= NOP;
      valid_q <= 1'b0;
      count_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      prev_q  <= prev_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign prevInstr   = prev_q;
  assign instr_valid = valid_q;
  assign halted      = (state_q == StHalt);
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: the bench plays the controller and a ROM, and
// every expected value below is worked out by hand from the intended behaviour.
module tb_fetch_unit;

  localparam logic [7:0] Nop = 8'hF0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  pccontrol;
  logic        flush;
  logic [7:0]  target;
  logic        stall;
  logic [7:0]  imem_rdata;
  logic        imem_ready;
  logic [7:0]  imem_addr;
  logic [7:0]  instr;
  logic [7:0]  prevInstr;
  logic        instr_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [7:0]  rom [256];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  assign imem_rdata = rom[imem_addr];

  fetch_unit #(
    .RESET_PC (8'h00),
    .NOP      (Nop)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pccontrol   (pccontrol),
    .flush       (flush),
    .target      (target),
    .stall       (stall),
    .imem_rdata  (imem_rdata),
    .imem_ready  (imem_ready),
    .imem_addr   (imem_addr),
    .instr       (instr),
    .prevInstr   (prevInstr),
    .instr_valid (instr_valid),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [7:0] pc, input logic [7:0] ins,
                              input logic [7:0] prv, input logic vld, input logic [15:0] cnt);
    check({tag, ".pc"},    imem_addr,   pc);
    check({tag, ".instr"}, instr,       ins);
    check({tag, ".prev"},  prevInstr,   prv);
    check({tag, ".valid"}, instr_valid, vld);
    check({tag, ".count"}, fetch_count, cnt);
    check({tag, ".halt"},  halted,      1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'h80;
    rom[8'h00] = 8'h11;
    rom[8'h01] = 8'h22;
    rom[8'h02] = 8'h33;
    rom[8'h03] = 8'h44;
    rom[8'h04] = 8'hB4;
    rom[8'h40] = 8'h99;
    rom[8'hFF] = 8'hEE;

    rst_n = 1'b0; pccontrol = 3'b000; flush = 1'b0; target = 8'h00;
    stall = 1'b0; imem_ready = 1'b1;
    #12;
    expect_state("reset", 8'h00, Nop, Nop, 1'b0, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Straight-line fetch; odd encodings 011/111 must behave as sequential.
    tick(); expect_state("seq1", 8'h01, 8'h11, Nop,   1'b1, 16'd1);
    tick(); expect_state("seq2", 8'h02, 8'h22, 8'h11, 1'b1, 16'd2);
    pccontrol = 3'b011;
    tick(); expect_state("seq3", 8'h03, 8'h33, 8'h22, 1'b1, 16'd3);
    pccontrol = 3'b111;
    tick(); expect_state("seq4", 8'h04, 8'h44, 8'h33, 1'b1, 16'd4);
    pccontrol = 3'b000;

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_state("stall", 8'h04, 8'h44, 8'h33, 1'b1, 16'd4);
    end
    stall = 1'b0;
    tick(); expect_state("resume", 8'h05, 8'hB4, 8'h44, 1'b1, 16'd5);

    // Taken relative branch back by 4 with the in-flight fetch flushed.
    pccontrol = 3'b001; target = 8'hFC; flush = 1'b1;
    tick(); expect_state("rel", 8'h01, Nop, 8'h44, 1'b0, 16'd5);
    pccontrol = 3'b000; flush = 1'b0;
    tick(); expect_state("rel_tgt", 8'h02, 8'h22, 8'h44, 1'b1, 16'd6);

    // Absolute jump while memory is not ready; 010 left driven is ignored once instr is a bubble.
    pccontrol = 3'b010; target = 8'h40; imem_ready = 1'b0;
    tick(); expect_state("abs", 8'h40, Nop, 8'h44, 1'b0, 16'd6);
    tick(); expect_state("abs_wait", 8'h40, Nop, 8'h44, 1'b0, 16'd6);
    imem_ready = 1'b1;
    tick(); expect_state("abs_tgt", 8'h41, 8'h99, 8'h44, 1'b1, 16'd7);
    pccontrol = 3'b000;

    // PC wrap from FF to 00.
    pccontrol = 3'b010; target = 8'hFF; flush = 1'b1;
    tick(); expect_state("jmp_ff", 8'hFF, Nop, 8'h44, 1'b0, 16'd7);
    pccontrol = 3'b000; flush = 1'b0;
    tick(); expect_state("fetch_ff", 8'h00, 8'hEE, 8'h44, 1'b1, 16'd8);
    tick(); expect_state("fetch_00", 8'h01, 8'h11, 8'hEE, 1'b1, 16'd9);

    // Flush on a sequential command drops the fetch but still advances pc.
    flush = 1'b1;
    tick(); expect_state("flush_seq", 8'h02, Nop, 8'hEE, 1'b0, 16'd9);
    flush = 1'b0;
    tick(); expect_state("after_flush", 8'h03, 8'h33, 8'hEE, 1'b1, 16'd10);

    // Halt, then verify nothing moves for 10 cycles whatever the inputs do.
    pccontrol = 3'b100;
    tick();
    check("halt.flag", halted, 1'b1);
    check("halt.instr", instr, Nop);
    check("halt.valid", instr_valid, 1'b0);
    check("halt.pc", imem_addr, 8'h03);
    pccontrol = 3'b001; target = 8'h10;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("halted.flag", halted, 1'b1);
      check("halted.instr", instr, Nop);
      check("halted.pc", imem_addr, 8'h03);
      check("halted.count", fetch_count, 16'd10);
    end
    pccontrol = 3'b000;

    // Asynchronous reset out of HALT, observed before any clock edge.
    rst_n = 1'b0;
    #2;
    expect_state("rst_halt", 8'h00, Nop, Nop, 1'b0, 16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(); expect_state("post_rst", 8'h01, 8'h11, Nop, 1'b1, 16'd1);

    // Reset in the middle of a stall overrides the hold.
    stall = 1'b1;
    tick();
    rst_n = 1'b0;
    #2;
    expect_state("rst_stall", 8'h00, Nop, Nop, 1'b0, 16'd0);
    stall = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 8'h00: program counter value loaded on reset.
REQ-002 Parameter NOP, default 8'h00: instruction value inserted as a bubble.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pccontrol  input  3  PC-update command from the controller, decoded from instr: 000 seq, 001 relative, 010 absolute, 100 halt, others treated as 000.
REQ-006 flush  input  1  from controller; discard the instruction currently being fetched.
REQ-007 target  input  8  branch offset (relative, two's complement) or absolute address.
REQ-008 stall  input  1  hazard hold from the datapath.
REQ-009 imem_rdata  input  8  instruction memory read data, valid in the same cycle as imem_addr.
REQ-010 imem_ready  input  1  instruction memory data valid this cycle.
REQ-011 imem_addr  output  8  combinational copy of pc.
REQ-012 instr  output  8  registered instruction presented to the controller.
REQ-013 prevInstr  output  8  registered previous valid instruction.
REQ-014 instr_valid  output  1  instr holds a real fetched instruction.
REQ-015 halted  output  1  fetch unit is in HALT state.
REQ-016 fetch_count  output  16  count of instructions loaded into instr.

Function
REQ-017 States RUN and HALT only; reset enters RUN.
REQ-018 pc is 8 bits and points to the next address to fetch; all pc arithmetic is modulo 256 (8'hFF+1 = 8'h00).
REQ-019 The effective command is pccontrol when instr_valid=1; it is 000 when instr_valid=0.
REQ-020 RUN, stall=1: pc, instr, prevInstr, instr_valid and fetch_count hold, with highest priority.
REQ-021 RUN, stall=0, effective command 100: next state HALT; pc holds; instr<=NOP; instr_valid<=0.
REQ-022 RUN, stall=0, effective command 001: pc <= pc + sign-extended target.
REQ-023 RUN, stall=0, effective command 010: pc <= target.
REQ-024 The redirect in REQ-022 and REQ-023 applies regardless of imem_ready, so a branch is never lost.
REQ-025 RUN, stall=0, flush=1: instr<=NOP; instr_valid<=0; prevInstr holds; fetch_count holds.
REQ-026 RUN, stall=0, flush=0, imem_ready=1: instr<=imem_rdata; prevInstr<=instr if instr_valid=1, else hold; instr_valid<=1; fetch_count += 1, wrapping at 16'hFFFF.
REQ-027 RUN, stall=0, flush=0, imem_ready=1, effective command 000: pc <= pc+1.
REQ-028 RUN, stall=0, flush=0, imem_ready=0: instr<=NOP; instr_valid<=0; pc holds unless redirected per REQ-024.
REQ-029 flush=1 with effective command 000 only drops the fetch and advances pc by 1.
REQ-030 HALT: all registers hold; halted=1; instr=NOP; instr_valid=0; exit only by reset.
REQ-031 halted is 1 exactly when state=HALT.

Reset
REQ-032 rst_n=0 asynchronously forces: state RUN, pc=RESET_PC, instr=NOP, prevInstr=NOP, instr_valid=0, halted=0, fetch_count=0.
REQ-033 Reset asserted mid-stall, mid-flush or in HALT overrides all other behaviour.
REQ-034 The first rising edge after rst_n deasserts with imem_ready=1 loads imem_rdata from RESET_PC.

Verification
REQ-035 Reset, imem_ready=1, ROM[0..3]=8'h11,22,33,44, pccontrol=000 -> instr 11,22,33,44 on consecutive cycles; prevInstr lags by one; fetch_count=4.
REQ-036 instr=branch at pc=8'h05 (fetched from 04), pccontrol=001, target=8'hFC, flush=1 -> next instr=NOP, valid=0, pc=8'h01; following cycle instr=ROM[01].
REQ-037 pc=8'hFF, sequential -> fetch from FF then from 00.
REQ-038 stall=1 for 3 cycles mid-stream -> instr, pc, fetch_count unchanged; resume with no lost or duplicated instruction.
REQ-039 imem_ready=0 for 2 cycles while instr is an absolute jump (pccontrol=010, target=8'h40) -> pc=8'h40 after one edge; NOPs until imem_ready=1, then instr=ROM[40].
REQ-040 pccontrol=100 -> halted=1 next cycle, instr=NOP held for 10 cycles; rst_n pulse -> halted=0, pc=RESET_PC.
